shift_reg_univ: RTL and testbench
=================================

// Module: shift_reg_univ
//
// PURPOSE
//   Parametrised universal shift register; next generation of the 4-bit serial-in
//   register with reset/set.
//   Adds configurable width, shift direction, parallel load, clock enable, and a
//   shift counter with a word-complete pulse.
//   Sits between a serial bit source and word-wide consumers (deserialiser/serialiser).
//
// PARAMETERS
//   WIDTH      4                 register width in bits, >= 2
//   RESET_VAL  {WIDTH{1'b0}}     Q value while r is asserted
//   SET_VAL    {WIDTH{1'b1}}     Q value loaded by synchronous set s
//
// PORTS
//   clk        in   1            rising-edge clock
//   r          in   1            asynchronous reset, active-low (0 = reset)
//   s          in   1            synchronous set, active-high
//   en         in   1            clock enable for shift/load operations
//   mode       in   2            00 hold, 01 shift right, 10 shift left, 11 parallel load
//   D          in   1            serial data in
//   rot        in   1            rotate select (only used with SHREG_ROTATE_EN)
//   P          in   WIDTH        parallel load data
//   Q          out  WIDTH        register contents
//   so         out  1            serial out: Q[0] in shift right, Q[WIDTH-1] otherwise
//   word_done  out  1            1-cycle pulse after WIDTH consecutive counted shifts
//
// BEHAVIOUR
//   - Reset (r=0, async, no clock needed)
//     - Q=RESET_VAL, cnt=0, word_done=0.
//     - Applies immediately mid-operation; deassertion takes effect at the next clk edge.
//   - Priority per rising edge: s > (en & mode).
//     - s=1: Q=SET_VAL, cnt=0, word_done=0; en and mode ignored.
//   - en=0 or mode=00: Q and cnt hold; word_done=0.
//   - mode=01 (shift right): Q <= {D, Q[WIDTH-1:1]}; D enters MSB.
//   - mode=10 (shift left):  Q <= {Q[WIDTH-2:0], D}; D enters LSB.
//   - mode=11 (load): Q <= P, cnt=0, word_done=0.
//   - so is combinational from Q and mode (mode=01 -> Q[0], else Q[WIDTH-1]).
//   - Counter
//     - cnt is internal, $clog2(WIDTH) bits, incremented on every executed shift.
//     - On the shift with cnt==WIDTH-1: cnt wraps to 0 and word_done=1 in the
//       following cycle (registered, exactly one cycle).
//     - Otherwise word_done=0.
//   - Direction change mid-word: cnt is not cleared; shifts in either direction count.
//   - Hold cycles between shifts: cnt is preserved.
//   - Latency: Q updates one edge after the command; word_done is registered with the
//     shift that completes the word.
//
// CONFIGURATION
//   SHREG_ROTATE_EN defined:
//     - rot=1 during a shift replaces D with the outgoing bit.
//       - right: Q <= {Q[0], Q[WIDTH-1:1]}
//       - left:  Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}
//     - Rotates count toward word_done like normal shifts.
//   SHREG_ROTATE_EN undefined:
//     - rot is ignored; all shifts take D.
//     - Port list is identical in both builds.
//
// TESTING  (WIDTH=4, 10 ns clock)
//   1 r=0 at t=7 ns between edges
//     -> Q=4'b0000 immediately; word_done=0; r=1 -> Q holds until the next command.
//   2 s=1 for one edge with en=1, mode=01, D=0
//     -> Q=4'b1111, cnt cleared; s beats the shift.
//   3 mode=01, en=1, D sequence 1,0,1,1 from Q=0000
//     -> Q=1000,0100,1010,1101; word_done=1 for exactly one cycle after the 4th shift.
//   4 mode=11, P=4'b1001, then mode=10 with D=0 for 2 edges, then en=0 for 3 edges
//     -> Q=1001,0010,0100,0100 held; so=0; no word_done.
//   5 Two shifts, two hold cycles, two shifts
//     -> word_done after the 4th shift only; assert r=0 mid-word -> next word needs 4 full shifts.
//   6 SHREG_ROTATE_EN, Q=0001, mode=01, rot=1, 4 edges
//     -> Q=1000,0100,0010,0001, word_done pulses; without the macro D is used instead.

Source files
------------

// File: rtl/shift_reg_univ.sv
// Universal shift register: right/left shift, parallel load, clock enable, and a
// shift counter that pulses word_done once per WIDTH shifts. Build macro SHREG_ROTATE_EN.
module shift_reg_univ #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             r,
    input  logic             s,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             D,
    input  logic             rot,
    input  logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] Q,
    output logic             so,
    output logic             word_done
);

    localparam int              CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [1:0]      MODE_HOLD  = 2'b00;
    localparam logic [1:0]      MODE_RIGHT = 2'b01;
    localparam logic [1:0]      MODE_LEFT  = 2'b10;
    localparam logic [1:0]      MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] shr_w, shl_w;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             word_done_q, word_done_d;
    logic             in_r, in_l;
    logic             shift_w;

`ifdef SHREG_ROTATE_EN
    // Rotation feeds the bit falling off the far end back into the vacated slot.
    assign in_r = rot ? q_q[0]       : D;
    assign in_l = rot ? q_q[WIDTH-1] : D;
`else
    logic unused_rot;
    assign unused_rot = rot;
    assign in_r       = D;
    assign in_l       = D;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign shr_w[gi]   = q_q[gi+1];
            assign shl_w[gi+1] = q_q[gi];
        end
    endgenerate
    assign shr_w[WIDTH-1] = in_r;
    assign shl_w[0]       = in_l;

    assign shift_w = en && ((mode == MODE_RIGHT) || (mode == MODE_LEFT));

    always_comb begin
        q_d         = q_q;
        cnt_d       = cnt_q;
        word_done_d = 1'b0;
        if (s) begin
            q_d   = SET_VAL;
            cnt_d = '0;
        end else if (en) begin
            case (mode)
                MODE_HOLD:  q_d = q_q;
                MODE_RIGHT: q_d = shr_w;
                MODE_LEFT:  q_d = shl_w;
                MODE_LOAD: begin
                    q_d   = P;
                    cnt_d = '0;
                end
                default:    q_d = q_q;
            endcase
            // Both directions share one counter, so a word may mix left and right shifts.
            if (shift_w) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    word_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            q_q         <= RESET_VAL;
            cnt_q       <= '0;
            word_done_q <= 1'b0;
        end else begin
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            word_done_q <= word_done_d;
        end
    end

    assign Q         = q_q;
    assign word_done = word_done_q;
    assign so        = (mode == MODE_RIGHT) ? q_q[0] : q_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ (WIDTH=4): stimulus queues expected Q/so/word_done,
// a monitor pops one entry after each clock edge (or after an asynchronous reset event).
module tb_shift_reg_univ;

    typedef struct {
        logic [3:0] q;
        logic       wd;
        logic       so;
    } exp_t;

    logic       clk = 1'b0;
    logic       r   = 1'b1;
    logic       s   = 1'b0;
    logic       en  = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       d   = 1'b0;
    logic       rot = 1'b0;
    logic [3:0] p   = 4'b0000;
    logic [3:0] q;
    logic       so;
    logic       word_done;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    event  chk_ev;

    shift_reg_univ #(
        .WIDTH    (4),
        .RESET_VAL(4'b0000),
        .SET_VAL  (4'b1111)
    ) dut (
        .clk      (clk),
        .r        (r),
        .s        (s),
        .en       (en),
        .mode     (mode),
        .D        (d),
        .rot      (rot),
        .P        (p),
        .Q        (q),
        .so       (so),
        .word_done(word_done)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [3:0] eq, input logic ewd, input string nm);
        exp_t e;
        e.q  = eq;
        e.wd = ewd;
        e.so = (mode == 2'b01) ? eq[0] : eq[3];
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // One command applied on a falling edge; its result is checked after the next rising edge.
    task automatic drive(input logic ts, input logic ten, input logic [1:0] tmode,
                         input logic td, input logic trot, input logic [3:0] tp,
                         input logic [3:0] eq, input logic ewd, input string nm);
        @(negedge clk);
        s = ts; en = ten; mode = tmode; d = td; rot = trot; p = tp;
        push_exp(eq, ewd, nm);
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (q !== e.q) begin
                    errors++;
                    $display("FAIL %s Q: got %b expected %b", nm, q, e.q);
                end
                checks++;
                if (word_done !== e.wd) begin
                    errors++;
                    $display("FAIL %s word_done: got %b expected %b", nm, word_done, e.wd);
                end
                checks++;
                if (so !== e.so) begin
                    errors++;
                    $display("FAIL %s so: got %b expected %b", nm, so, e.so);
                end
                $display("check %s: Q=%b word_done=%b so=%b", nm, q, word_done, so);
            end
        end
    end

    initial begin : stimulus
        int wait_cycles;
        // Asynchronous reset between clock edges
        #7;
        r = 1'b0;
        push_exp(4'b0000, 1'b0, "async_reset");
        -> chk_ev;
        #5 r = 1'b1;
        drive(0, 0, 2'b00, 0, 0, 4'h0, 4'b0000, 0, "hold_after_reset");

        // Two shifts, then set must win and clear the counter
        drive(0, 1, 2'b01, 1, 0, 4'h0, 4'b1000, 0, "sr_pre1");
        drive(0, 1, 2'b01, 1, 0, 4'h0, 4'b1100, 0, "sr_pre2");
        drive(1, 1, 2'b01, 0, 0, 4'h0, 4'b1111, 0, "set_beats_shift");
        drive(0, 1, 2'b01, 1, 0, 4'h0, 4'b1111, 0, "sr_after_set1");
        drive(0, 1, 2'b01, 0, 0, 4'h0, 4'b0111, 0, "sr_after_set2");
        drive(0, 1, 2'b01, 1, 0, 4'h0, 4'b1011, 0, "sr_after_set3");
        drive(0, 1, 2'b01, 1, 0, 4'h0, 4'b1101, 1, "sr_after_set4");
        drive(0, 0, 2'b01, 0, 0, 4'h0, 4'b1101, 0, "en_low_pulse_end");

        // Shift right 1,0,1,1 from zero
        drive(0, 1, 2'b11, 0, 0, 4'h0, 4'b0000, 0, "load_zero");
        drive(0, 1, 2'b01, 1, 0, 4'h0, 4'b1000, 0, "sr1");
        drive(0, 1, 2'b01, 0, 0, 4'h0, 4'b0100, 0, "sr2");
        drive(0, 1, 2'b01, 1, 0, 4'h0, 4'b1010, 0, "sr3");
        drive(0, 1, 2'b01, 1, 0, 4'h0, 4'b1101, 1, "sr4_word_done");
        drive(0, 1, 2'b00, 0, 0, 4'h0, 4'b1101, 0, "mode_hold_pulse_end");

        // Load then shift left, then clock enable low
        drive(0, 1, 2'b11, 0, 0, 4'h9, 4'b1001, 0, "load_1001");
        drive(0, 1, 2'b10, 0, 0, 4'h0, 4'b0010, 0, "sl1");
        drive(0, 1, 2'b10, 0, 0, 4'h0, 4'b0100, 0, "sl2");
        drive(0, 0, 2'b10, 1, 0, 4'hF, 4'b0100, 0, "en_low1");
        drive(0, 0, 2'b10, 1, 0, 4'hF, 4'b0100, 0, "en_low2");
        drive(0, 0, 2'b10, 1, 0, 4'hF, 4'b0100, 0, "en_low3");

        // Counter kept across holds and direction changes
        drive(0, 1, 2'b11, 0, 0, 4'h0, 4'b0000, 0, "load_zero2");
        drive(0, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 0, "mix_sr");
        drive(0, 1, 2'b10, 1, 0, 4'h0, 4'b0001, 0, "mix_sl");
        drive(0, 0, 2'b01, 1, 0, 4'h0, 4'b0001, 0, "mix_hold_en");
        drive(0, 1, 2'b00, 1, 0, 4'h0, 4'b0001, 0, "mix_hold_mode");
        drive(0, 1, 2'b10, 1, 0, 4'h0, 4'b0011, 0, "mix_sl2");
        drive(0, 1, 2'b01, 0, 0, 4'h0, 4'b0001, 1, "mix_sr2_word_done");

        // Reset mid-word: a fresh word needs four full shifts
        drive(0, 1, 2'b10, 1, 0, 4'h0, 4'b0011, 0, "pre_rst_sl1");
        drive(0, 1, 2'b10, 0, 0, 4'h0, 4'b0110, 0, "pre_rst_sl2");
        @(posedge clk);
        #2 r = 1'b0;
        push_exp(4'b0000, 1'b0, "async_reset_mid_word");
        -> chk_ev;
        #2 r = 1'b1;
        drive(0, 1, 2'b10, 1, 0, 4'h0, 4'b0001, 0, "post_rst_sl1");
        drive(0, 1, 2'b10, 1, 0, 4'h0, 4'b0011, 0, "post_rst_sl2");
        drive(0, 1, 2'b10, 1, 0, 4'h0, 4'b0111, 0, "post_rst_sl3");
        drive(0, 1, 2'b10, 1, 0, 4'h0, 4'b1111, 1, "post_rst_sl4");
        drive(0, 1, 2'b00, 0, 0, 4'h0, 4'b1111, 0, "post_rst_hold");

        // Rotate select: recirculates with the macro, ignored (D=0 shifted in) without
        drive(0, 1, 2'b11, 0, 0, 4'h1, 4'b0001, 0, "load_0001");
`ifdef SHREG_ROTATE_EN
        drive(0, 1, 2'b01, 0, 1, 4'h0, 4'b1000, 0, "rot_r1");
        drive(0, 1, 2'b01, 0, 1, 4'h0, 4'b0100, 0, "rot_r2");
        drive(0, 1, 2'b01, 0, 1, 4'h0, 4'b0010, 0, "rot_r3");
        drive(0, 1, 2'b01, 0, 1, 4'h0, 4'b0001, 1, "rot_r4");
        drive(0, 1, 2'b11, 0, 0, 4'h8, 4'b1000, 0, "load_1000");
        drive(0, 1, 2'b10, 0, 1, 4'h0, 4'b0001, 0, "rot_l1");
`else
        drive(0, 1, 2'b01, 0, 1, 4'h0, 4'b0000, 0, "rot_ignored_r1");
        drive(0, 1, 2'b01, 0, 1, 4'h0, 4'b0000, 0, "rot_ignored_r2");
        drive(0, 1, 2'b01, 0, 1, 4'h0, 4'b0000, 0, "rot_ignored_r3");
        drive(0, 1, 2'b01, 0, 1, 4'h0, 4'b0000, 1, "rot_ignored_r4");
        drive(0, 1, 2'b11, 0, 0, 4'h8, 4'b1000, 0, "load_1000");
        drive(0, 1, 2'b10, 0, 1, 4'h0, 4'b0000, 0, "rot_ignored_l1");
`endif
        drive(0, 0, 2'b00, 0, 0, 4'h0, (rot_build() ? 4'b0001 : 4'b0000), 0, "final_hold");

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic bit rot_build();
`ifdef SHREG_ROTATE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

endmodule
